// File: rtl/rf_wb_pkg.sv
// Shared widths and payload type for the register-file writeback queue.
package rf_wb_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Circular buffer accepting up to two pushes and one pop per cycle; exposes its
// storage, read pointer and occupancy so the owner can scan live entries.
module wb_fifo2
  import rf_wb_pkg::*;
#(
  parameter  int unsigned W     = $bits(wb_entry_t),
  parameter  int unsigned DEPTH = rf_wb_pkg::DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push0,
  input  logic [W-1:0]              din0,
  input  logic                      push1,
  input  logic [W-1:0]              din1,
  input  logic                      pop,
  output logic [DEPTH-1:0][W-1:0]   slots,
  output logic [PTR_W-1:0]          rd_ptr,
  output logic [CNT_W-1:0]          count
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [CNT_W-1:0] n_push;

  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
  assign n_push    = CNT_W'(push0) + CNT_W'(push1);

  // Storage carries no reset; only entries inside [rd_ptr, rd_ptr+count) are meaningful.
  always_ff @(posedge clk) begin
    if (push0) slots[wr_ptr]    <= din0;
    if (push1) slots[wr_ptr_p1] <= din1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + n_push - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Merges load and ALU results into the register file's single write port, with a
// pending-write scoreboard. Define WB_FORWARD_EN to add youngest-value forwarding.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int unsigned DATA_W = rf_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = rf_wb_pkg::ADDR_W,
  parameter int unsigned DEPTH  = rf_wb_pkg::DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 in_ready,
  output logic                 rf_wr_en,
  output logic [ADDR_W-1:0]    rf_wr_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 overflow,
  input  logic [ADDR_W-1:0]    fwd_addr,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                         ld_live, alu_live;
  logic                         ld_ok, alu_ok;
  logic                         push0, push1, pop;
  entry_t                       ld_ent, alu_ent, din0;
  logic [DEPTH-1:0][ENT_W-1:0]  slots;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             count;
  entry_t                       head;

  // Writes to r0 are architecturally dead and never occupy a slot.
  assign ld_live  = ld_valid  && (ld_rd  != '0);
  assign alu_live = alu_valid && (alu_rd != '0);
  assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign ld_ok    = ld_live  && in_ready;
  assign alu_ok   = alu_live && in_ready;

  assign ld_ent  = '{rd: ld_rd,  data: ld_data};
  assign alu_ent = '{rd: alu_rd, data: alu_data};

  // Compact so slot 0 is always the older instruction (load ahead of ALU).
  assign push0 = ld_ok || alu_ok;
  assign push1 = ld_ok && alu_ok;
  assign din0  = ld_ok ? ld_ent : alu_ent;
  assign pop   = (count != '0);

  wb_fifo2 #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push0  (push0),
    .din0   (din0),
    .push1  (push1),
    .din1   (alu_ent),
    .pop    (pop),
    .slots  (slots),
    .rd_ptr (rd_ptr),
    .count  (count)
  );

  assign head = entry_t'(slots[rd_ptr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= pop;
      if (pop) begin
        rf_wr_addr <= head.rd;
        rf_wr_data <= head.data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (!in_ready && (ld_live || alu_live)) begin
      overflow <= 1'b1;
    end
  end

  always_comb begin
    entry_t e;
    pending = '0;
    e       = '0;
    if (rf_wr_en) pending[rf_wr_addr] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e = entry_t'(slots[rd_ptr + PTR_W'(i)]);
      if (CNT_W'(i) < count) pending[e.rd] = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the last match left standing is the newest value.
  always_comb begin
    entry_t e;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    e        = '0;
    if (fwd_addr != '0) begin
      if (rf_wr_en && (rf_wr_addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        e = entry_t'(slots[rd_ptr + PTR_W'(i)]);
        if ((CNT_W'(i) < count) && (e.rd == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = e.data;
        end
      end
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed and randomized checks of rf_writeback_queue against a queue-based model.
module tb_rf_writeback_queue;
  import rf_wb_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                ld_valid, alu_valid;
  logic [ADDR_W-1:0]   ld_rd, alu_rd, fwd_addr;
  logic [DATA_W-1:0]   ld_data, alu_data;
  logic                in_ready, rf_wr_en, overflow, fwd_hit;
  logic [ADDR_W-1:0]   rf_wr_addr;
  logic [DATA_W-1:0]   rf_wr_data, fwd_data;
  logic [NUM_REGS-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ordered list of queued writes plus the write-port stage.
  wb_entry_t           m_q[$];
  logic                m_en;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_data;
  logic                m_ovf;
  logic [NUM_REGS-1:0] pend_s;

  rf_writeback_queue dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .in_ready   (in_ready),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .pending    (pending),
    .overflow   (overflow),
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_ovf  = 1'b0;
  endtask

  function automatic logic model_ready();
    return (DEPTH - m_q.size()) >= 2;
  endfunction

  task automatic compare_all();
    logic [NUM_REGS-1:0] ep;
    logic                eh;
    logic [DATA_W-1:0]   ed;
    ep = '0;
    eh = 1'b0;
    ed = '0;
    if (m_en) ep[m_addr] = 1'b1;
    foreach (m_q[i]) ep[m_q[i].rd] = 1'b1;
`ifdef WB_FORWARD_EN
    if (fwd_addr != '0) begin
      for (int i = m_q.size() - 1; i >= 0 && !eh; i--)
        if (m_q[i].rd == fwd_addr) begin eh = 1'b1; ed = m_q[i].data; end
      if (!eh && m_en && m_addr == fwd_addr) begin eh = 1'b1; ed = m_data; end
    end
`endif
    check("in_ready", 32'(in_ready), 32'(model_ready()));
    check("wr_en", 32'(rf_wr_en), 32'(m_en));
    check("wr_addr", 32'(rf_wr_addr), 32'(m_addr));
    check("wr_data", 32'(rf_wr_data), 32'(m_data));
    check("pending", 32'(pending), 32'(ep));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("fwd_hit", 32'(fwd_hit), 32'(eh));
    if (eh) check("fwd_data", 32'(fwd_data), 32'(ed));
    pend_s = pending;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic rdy;
    rdy = model_ready();
    if (m_q.size() > 0) begin
      wb_entry_t h;
      h      = m_q.pop_front();
      m_en   = 1'b1;
      m_addr = h.rd;
      m_data = h.data;
    end else begin
      m_en = 1'b0;
    end
    if (rdy) begin
      if (ld_valid && ld_rd != '0)   m_q.push_back('{rd: ld_rd,  data: ld_data});
      if (alu_valid && alu_rd != '0) m_q.push_back('{rd: alu_rd, data: alu_data});
    end else if ((ld_valid && ld_rd != '0) || (alu_valid && alu_rd != '0)) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic cycle(input logic lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ldd,
                       input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input logic [ADDR_W-1:0] fa);
    @(negedge clk);
    ld_valid  = lv;  ld_rd  = lr;  ld_data  = ldd;
    alu_valid = av;  alu_rd = ar;  alu_data = ad;
    fwd_addr  = fa;
    #1;
    compare_all();
    model_step();
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] fa);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, fa);
  endtask

  initial begin
    int pc;
    rst = 1'b1;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    fwd_addr = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, then single ALU write: pending for exactly two cycles.
    idle(1, 3'd3);
    cycle(1'b0, '0, '0, 1'b1, 3'd3, 16'h1234, 3'd3);
    pc = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1, 3'd3);
      if (pend_s[3]) pc++;
    end
    check("t1_pend_cycles", 32'(pc), 32'd2);

    // Same-cycle load and ALU: load drains first.
    cycle(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd5, 16'h0055, 3'd5);
    idle(4, 3'd2);

    // Back-to-back dual pushes fill the queue; extra push overflows and sticks.
    cycle(1'b1, 3'd1, 16'h1111, 1'b1, 3'd6, 16'h6666, 3'd6);
    cycle(1'b1, 3'd7, 16'h7777, 1'b1, 3'd6, 16'h6006, 3'd6);
    check("t3_not_ready", 32'(model_ready()), 32'd0);
    cycle(1'b0, '0, '0, 1'b1, 3'd4, 16'h4444, 3'd6);
    idle(6, 3'd4);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Writes to r0 are dropped entirely.
    cycle(1'b0, '0, '0, 1'b1, 3'd0, 16'hFFFF, 3'd0);
    idle(3, 3'd0);
    check("t4_pend_zero", 32'(pend_s), 32'd0);

    // Two queued writes to r4: forwarding returns the younger.
    cycle(1'b0, '0, '0, 1'b1, 3'd4, 16'h0001, 3'd4);
    cycle(1'b0, '0, '0, 1'b1, 3'd4, 16'h0002, 3'd4);
    idle(1, 3'd4);
`ifdef WB_FORWARD_EN
    check("t5_hit", 32'(fwd_hit), 32'd1);
    check("t5_data", 32'(fwd_data), 32'h0002);
`else
    check("t5_hit", 32'(fwd_hit), 32'd0);
`endif
    idle(3, 3'd4);

    // Async reset with entries queued discards them immediately.
    cycle(1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hA002, 3'd1);
    cycle(1'b0, '0, '0, 1'b1, 3'd3, 16'hA003, 3'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_en_drop", 32'(rf_wr_en), 32'd0);
    check("t6_pend_clr", 32'(pending), 32'd0);
    check("t6_ovf_clr", 32'(overflow), 32'd0);
    @(negedge clk);
    ld_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    idle(5, 3'd1);

    // Randomized traffic that honours in_ready.
    for (int i = 0; i < 400; i++) begin
      logic lv, av;
      lv = ($urandom_range(0, 2) != 0) && model_ready();
      av = ($urandom_range(0, 2) != 0) && model_ready();
      cycle(lv, ADDR_W'($urandom_range(0, NUM_REGS - 1)), DATA_W'($urandom),
            av, ADDR_W'($urandom_range(0, NUM_REGS - 1)), DATA_W'($urandom),
            ADDR_W'($urandom_range(0, NUM_REGS - 1)));
    end
    idle(6, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
